// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg: shared FSM states, funct3 codes, exception causes and the exception pack.
package mem_access_unit_pkg;
    typedef enum logic [1:0] {IDLE, REQ, DONE, DRAIN} state_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;
    localparam logic [2:0] F3_ILL = 3'b111;

    localparam logic [63:0] CAUSE_ILLEGAL_INSTR  = 64'd2;
    localparam logic [63:0] CAUSE_LOAD_MISALIGN  = 64'd4;
    localparam logic [63:0] CAUSE_STORE_MISALIGN = 64'd6;

    typedef struct packed {
        logic        except;
        logic [63:0] epc;
        logic [63:0] ecause;
        logic [63:0] etval;
    } ExceptStruct;

    function automatic logic [7:0] width_mask(input logic [1:0] size);
        return size == 2'd0 ? 8'h01 : size == 2'd1 ? 8'h03 : size == 2'd2 ? 8'h0F : 8'hFF;
    endfunction

    // Low address bits that must be zero for a naturally aligned access of this size.
    function automatic logic [2:0] align_bits(input logic [1:0] size);
        return size == 2'd0 ? 3'd0 : size == 2'd1 ? 3'd1 : size == 2'd2 ? 3'd3 : 3'd7;
    endfunction
endpackage

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: doubleword data-memory bus between the access unit (master) and memory (slave).
interface mem_access_unit_if;
    logic        req;
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wmask;
    logic        ack;
    logic [63:0] rdata;

    modport master (output req, we, addr, wdata, wmask, input ack, rdata);
    modport slave  (input req, we, addr, wdata, wmask, output ack, rdata);
endinterface

// File: rtl/mem_access_unit_load_align.sv
// load_align: picks the addressed byte/half/word/dword out of a read doubleword and sign/zero-extends it.
module load_align
    import mem_access_unit_pkg::*;
(
    input  logic [63:0] rdata_i,
    input  logic [2:0]  off_i,
    input  logic [2:0]  funct3_i,
    output logic [63:0] data_o
);
    logic [63:0] sh;

    assign sh = rdata_i >> {off_i, 3'b000};

    always_comb begin
        data_o = funct3_i == F3_LB  ? {{56{sh[7]}}, sh[7:0]} :
                 funct3_i == F3_LH  ? {{48{sh[15]}}, sh[15:0]} :
                 funct3_i == F3_LW  ? {{32{sh[31]}}, sh[31:0]} :
                 funct3_i == F3_LD  ? sh :
                 funct3_i == F3_LBU ? {56'd0, sh[7:0]} :
                 funct3_i == F3_LHU ? {48'd0, sh[15:0]} :
                 funct3_i == F3_LWU ? {32'd0, sh[31:0]} : '0;
    end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store sequencer on a doubleword bus with flush draining.
// Define MISALIGN_EXCEPT_EN to trap non-naturally-aligned accesses instead of truncating them.
module mem_access_unit
    import mem_access_unit_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mem_valid,
    input  logic                     mem_re,
    input  logic                     mem_we,
    input  logic [2:0]               mem_funct3,
    input  logic [63:0]              mem_addr_in,
    input  logic [63:0]              mem_wdata_in,
    input  logic [63:0]              mem_pc,
    input  logic                     mem_flush,
    input  logic                     pipe_hold,
    input  ExceptStruct              except_in,
    mem_access_unit_if.master        dmem,
    output logic [63:0]              mem_truncout,
    output logic                     mem_stall,
    output ExceptStruct              except_out
);
    state_e      state_q, state_d;
    logic [63:0] addr_q, wdata_q, data_q, data_d, load_data;
    logic [7:0]  wmask_q;
    logic [2:0]  off_q, funct3_q;
    logic        we_q, mem_op, illegal, misalign, new_exc, issue, req;
    ExceptStruct exc_new;

    assign mem_op  = mem_valid & (mem_re | mem_we);
    assign illegal = mem_funct3 == F3_ILL;
`ifdef MISALIGN_EXCEPT_EN
    assign misalign = |(mem_addr_in[2:0] & align_bits(mem_funct3[1:0]));
`else
    assign misalign = 1'b0;
`endif
    assign new_exc = mem_op & (illegal | misalign);
    assign issue   = state_q == IDLE & mem_op & ~new_exc & ~except_in.except & ~mem_flush;
    assign req     = state_q == REQ | state_q == DRAIN;

    always_comb begin
        exc_new.except = 1'b1;
        exc_new.epc    = mem_pc;
        exc_new.ecause = illegal ? CAUSE_ILLEGAL_INSTR : mem_we ? CAUSE_STORE_MISALIGN : CAUSE_LOAD_MISALIGN;
        exc_new.etval  = illegal ? '0 : mem_addr_in;
        except_out     = new_exc ? exc_new : except_in;
    end

    always_comb begin
        state_d   = state_q;
        mem_stall = 1'b0;
        case (state_q)
            IDLE: begin
                mem_stall = issue;
                state_d   = issue ? REQ : IDLE;
            end
            REQ: begin
                mem_stall = 1'b1;
                state_d   = mem_flush ? (dmem.ack ? IDLE : DRAIN) : (dmem.ack ? DONE : REQ);
            end
            DONE:  state_d = (mem_flush | ~pipe_hold) ? IDLE : DONE;
            DRAIN: begin
                mem_stall = mem_op;
                state_d   = dmem.ack ? IDLE : DRAIN;
            end
            default: state_d = IDLE;
        endcase
    end

    load_align u_load_align (
        .rdata_i  (dmem.rdata),
        .off_i    (off_q),
        .funct3_i (funct3_q),
        .data_o   (load_data)
    );

    // Only a clean ack in REQ delivers data; flushed and drained responses are dropped.
    assign data_d = (state_q == REQ & dmem.ack & ~mem_flush) ? (we_q ? '0 : load_data) : data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            data_q   <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wmask_q  <= '0;
            off_q    <= '0;
            funct3_q <= '0;
            we_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            if (issue) begin
                addr_q   <= {mem_addr_in[63:3], 3'b000};
                wdata_q  <= mem_we ? mem_wdata_in << {mem_addr_in[2:0], 3'b000} : '0;
                wmask_q  <= width_mask(mem_funct3[1:0]) << mem_addr_in[2:0];
                off_q    <= mem_addr_in[2:0];
                funct3_q <= mem_funct3;
                we_q     <= mem_we;
            end
        end
    end

    assign dmem.req     = req;
    assign dmem.we      = req & we_q;
    assign dmem.addr    = req ? addr_q : '0;
    assign dmem.wdata   = req ? wdata_q : '0;
    assign dmem.wmask   = req ? wmask_q : '0;
    assign mem_truncout = state_q == DONE ? data_q : '0;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: vector table with scoreboard plus hand-written flush/hold/reset sequences.
module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    typedef struct {
        logic [2:0]  f3;
        logic        we;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] rdata;
        int          ack_cyc;
        logic [63:0] e_addr;
        logic [7:0]  e_mask;
        logic [63:0] e_wdata;
        logic [63:0] e_trunc;
        logic        e_exc;
        logic [63:0] e_cause;
        logic [63:0] e_tval;
    } vec_t;

    logic clk = 1'b0, rst = 1'b1;
    logic mem_valid = 0, mem_re = 0, mem_we = 0, mem_flush = 0, pipe_hold = 0;
    logic [2:0] mem_funct3 = '0;
    logic [63:0] mem_addr_in = '0, mem_wdata_in = '0, mem_pc = '0, mem_truncout;
    logic mem_stall;
    ExceptStruct except_in, except_out;
    int passed = 0, total = 0;
    logic [63:0] exp_q[$];
    vec_t vecs[13];

    mem_access_unit_if bus();

    mem_access_unit dut (
        .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_re(mem_re), .mem_we(mem_we),
        .mem_funct3(mem_funct3), .mem_addr_in(mem_addr_in), .mem_wdata_in(mem_wdata_in),
        .mem_pc(mem_pc), .mem_flush(mem_flush), .pipe_hold(pipe_hold), .except_in(except_in),
        .dmem(bus), .mem_truncout(mem_truncout), .mem_stall(mem_stall), .except_out(except_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic vec_t mk(input logic [2:0] f3, input logic we, input logic [63:0] addr,
                                input logic [63:0] wdata, input logic [63:0] rdata, input int ack_cyc,
                                input logic [63:0] e_addr, input logic [7:0] e_mask, input logic [63:0] e_wdata,
                                input logic [63:0] e_trunc, input logic e_exc, input logic [63:0] e_cause,
                                input logic [63:0] e_tval);
        vec_t v;
        v.f3 = f3; v.we = we; v.addr = addr; v.wdata = wdata; v.rdata = rdata; v.ack_cyc = ack_cyc;
        v.e_addr = e_addr; v.e_mask = e_mask; v.e_wdata = e_wdata; v.e_trunc = e_trunc;
        v.e_exc = e_exc; v.e_cause = e_cause; v.e_tval = e_tval;
        return v;
    endfunction

    task automatic drive(input logic [2:0] f3, input logic we, input logic [63:0] addr,
                         input logic [63:0] wdata, input logic [63:0] pc);
        mem_valid = 1; mem_re = !we; mem_we = we; mem_funct3 = f3;
        mem_addr_in = addr; mem_wdata_in = wdata; mem_pc = pc;
    endtask

    task automatic idle_inputs();
        mem_valid = 0; mem_re = 0; mem_we = 0;
    endtask

    task automatic do_op(input int idx, input vec_t v);
        int req_cnt = 0, stall_cnt = 0;
        logic done = 0;
        logic [63:0] pc = 64'h8000_0000 + 64'(idx * 4);
        drive(v.f3, v.we, v.addr, v.wdata, pc);
        exp_q.push_back(v.e_trunc);
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.req) begin
                req_cnt++;
                chk($sformatf("v%0d_addr", idx), bus.addr, v.e_addr);
                chk($sformatf("v%0d_wmask", idx), 64'(bus.wmask), 64'(v.e_mask));
                chk($sformatf("v%0d_wdata", idx), bus.wdata, v.e_wdata);
                chk($sformatf("v%0d_we", idx), 64'(bus.we), 64'(v.we));
                if (req_cnt == v.ack_cyc) begin
                    bus.ack = 1; bus.rdata = v.rdata;
                end
            end
            if (!mem_stall) begin
                done = 1;
                break;
            end
            stall_cnt++;
            @(posedge clk); #1;
            bus.ack = 0; bus.rdata = '0;
        end
        chk($sformatf("v%0d_timeout", idx), 64'(done), 64'd1);
        chk($sformatf("v%0d_truncout", idx), mem_truncout, exp_q.pop_front());
        if (v.e_exc) begin
            chk($sformatf("v%0d_no_req", idx), 64'(req_cnt), 64'd0);
            chk($sformatf("v%0d_except", idx), 64'(except_out.except), 64'd1);
            chk($sformatf("v%0d_ecause", idx), except_out.ecause, v.e_cause);
            chk($sformatf("v%0d_etval", idx), except_out.etval, v.e_tval);
            chk($sformatf("v%0d_epc", idx), except_out.epc, pc);
        end else begin
            chk($sformatf("v%0d_stall_cycles", idx), 64'(stall_cnt), 64'(1 + v.ack_cyc));
            chk($sformatf("v%0d_except", idx), 64'(except_out.except), 64'd0);
        end
        @(posedge clk); #1;
        idle_inputs();
    endtask

    initial begin
        except_in = '0;
        bus.ack = 0; bus.rdata = '0;
        vecs[0]  = mk(F3_LD, 0, 64'h1000, 0, 64'h8877665544332211, 3, 64'h1000, 8'hFF, 0, 64'h8877665544332211, 0, 0, 0);
        vecs[1]  = mk(F3_LB, 0, 64'h1007, 0, 64'h80AABBCCDDEEFF11, 1, 64'h1000, 8'h80, 0, 64'hFFFFFFFFFFFFFF80, 0, 0, 0);
        vecs[2]  = mk(F3_LBU, 0, 64'h1007, 0, 64'h80AABBCCDDEEFF11, 1, 64'h1000, 8'h80, 0, 64'h80, 0, 0, 0);
        vecs[3]  = mk(F3_LH, 1, 64'h2002, 64'hBEEF, 0, 2, 64'h2000, 8'h0C, 64'h00000000BEEF0000, 0, 0, 0, 0);
        vecs[4]  = mk(F3_LH, 0, 64'h1002, 0, 64'h112233449ABC5566, 1, 64'h1000, 8'h0C, 0, 64'hFFFFFFFFFFFF9ABC, 0, 0, 0);
        vecs[5]  = mk(F3_LHU, 0, 64'h1002, 0, 64'h112233449ABC5566, 2, 64'h1000, 8'h0C, 0, 64'h9ABC, 0, 0, 0);
        vecs[6]  = mk(F3_LW, 0, 64'h1004, 0, 64'h8765432100000000, 1, 64'h1000, 8'hF0, 0, 64'hFFFFFFFF87654321, 0, 0, 0);
        vecs[7]  = mk(F3_LWU, 0, 64'h1004, 0, 64'h8765432100000000, 1, 64'h1000, 8'hF0, 0, 64'h87654321, 0, 0, 0);
        vecs[8]  = mk(F3_LD, 1, 64'h2008, 64'h0123456789ABCDEF, 0, 1, 64'h2008, 8'hFF, 64'h0123456789ABCDEF, 0, 0, 0, 0);
        vecs[9]  = mk(F3_LB, 1, 64'h2005, 64'h5A, 0, 1, 64'h2000, 8'h20, 64'h00005A0000000000, 0, 0, 0, 0);
`ifdef MISALIGN_EXCEPT_EN
        vecs[10] = mk(F3_LW, 1, 64'h2006, 64'hDEADBEEF, 0, 1, 0, 0, 0, 0, 1, 64'd6, 64'h2006);
        vecs[11] = mk(F3_LW, 0, 64'h3002, 0, 64'h0000123456780000, 1, 0, 0, 0, 0, 1, 64'd4, 64'h3002);
`else
        vecs[10] = mk(F3_LW, 1, 64'h2006, 64'hDEADBEEF, 0, 1, 64'h2000, 8'hC0, 64'hBEEF000000000000, 0, 0, 0, 0);
        vecs[11] = mk(F3_LW, 0, 64'h3002, 0, 64'h0000123456780000, 1, 64'h3000, 8'h3C, 0, 64'h12345678, 0, 0, 0);
`endif
        vecs[12] = mk(3'b111, 0, 64'h1000, 0, 0, 1, 0, 0, 0, 0, 1, 64'd2, 64'd0);

        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("reset_req", 64'(bus.req), 64'd0);
        chk("reset_stall", 64'(mem_stall), 64'd0);
        chk("reset_truncout", mem_truncout, 64'd0);
        chk("reset_except", except_out, 64'd0);

        @(posedge clk); #1;
        drive(F3_LD, 0, 64'h1000, 0, 64'h100);
        mem_re = 0;
        @(negedge clk);
        chk("nonmem_stall", 64'(mem_stall), 64'd0);
        chk("nonmem_truncout", mem_truncout, 64'd0);
        @(posedge clk); #1;
        mem_valid = 0; mem_re = 1;
        @(negedge clk);
        chk("invalid_stall", 64'(mem_stall), 64'd0);
        chk("invalid_req", 64'(bus.req), 64'd0);
        @(posedge clk); #1;
        idle_inputs();

        for (int i = 0; i < 13; i++) do_op(i, vecs[i]);

        // Incoming exception passes through and blocks the bus.
        drive(F3_LD, 0, 64'h1000, 0, 64'h200);
        except_in = '{except: 1'b1, epc: 64'h200, ecause: 64'd5, etval: 64'h77};
        @(negedge clk);
        chk("excin_stall", 64'(mem_stall), 64'd0);
        chk("excin_pass", except_out.etval, 64'h77);
        chk("excin_cause", except_out.ecause, 64'd5);
        @(posedge clk); #1;
        except_in = '0; idle_inputs();
        @(negedge clk);
        chk("excin_no_req", 64'(bus.req), 64'd0);

        // Flush in IDLE: no stall, no request.
        @(posedge clk); #1;
        drive(F3_LD, 0, 64'h1000, 0, 64'h300);
        mem_flush = 1;
        @(negedge clk);
        chk("flush_idle_stall", 64'(mem_stall), 64'd0);
        @(posedge clk); #1;
        mem_flush = 0; idle_inputs();
        @(negedge clk);
        chk("flush_idle_req", 64'(bus.req), 64'd0);

        // Flush in REQ without ack -> DRAIN until the late ack.
        @(posedge clk); #1;
        drive(F3_LD, 0, 64'h1000, 0, 64'h400);
        @(posedge clk); #1;
        mem_flush = 1; idle_inputs();
        @(negedge clk);
        chk("drain_req_in_req", 64'(bus.req), 64'd1);
        @(posedge clk); #1;
        mem_flush = 0;
        @(negedge clk);
        chk("drain_req", 64'(bus.req), 64'd1);
        chk("drain_stall", 64'(mem_stall), 64'd0);
        chk("drain_truncout", mem_truncout, 64'd0);
        @(posedge clk); #1;
        drive(F3_LD, 0, 64'h1008, 0, 64'h404);
        @(negedge clk);
        chk("drain_req_held", 64'(bus.req), 64'd1);
        chk("drain_stall_newop", 64'(mem_stall), 64'd1);
        bus.ack = 1; bus.rdata = 64'hDEAD;
        @(posedge clk); #1;
        bus.ack = 0; idle_inputs();
        @(negedge clk);
        chk("drain_done_req", 64'(bus.req), 64'd0);
        chk("drain_done_truncout", mem_truncout, 64'd0);

        // Flush and ack together in REQ -> straight to IDLE, data dropped.
        @(posedge clk); #1;
        drive(F3_LD, 0, 64'h1000, 0, 64'h500);
        @(posedge clk); #1;
        @(negedge clk);
        mem_flush = 1; bus.ack = 1; bus.rdata = 64'h1234;
        idle_inputs();
        @(posedge clk); #1;
        mem_flush = 0; bus.ack = 0;
        @(negedge clk);
        chk("flushack_req", 64'(bus.req), 64'd0);
        chk("flushack_truncout", mem_truncout, 64'd0);
        chk("flushack_stall", 64'(mem_stall), 64'd0);

        // pipe_hold keeps DONE and its data.
        @(posedge clk); #1;
        drive(F3_LD, 0, 64'h1000, 0, 64'h600);
        pipe_hold = 1;
        exp_q.push_back(64'hCAFEF00DCAFEF00D);
        @(posedge clk); #1;
        @(negedge clk);
        bus.ack = 1; bus.rdata = 64'hCAFEF00DCAFEF00D;
        @(posedge clk); #1;
        bus.ack = 0;
        @(negedge clk);
        chk("hold_truncout", mem_truncout, exp_q.pop_front());
        chk("hold_stall", 64'(mem_stall), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("hold_truncout_kept", mem_truncout, 64'hCAFEF00DCAFEF00D);
        @(posedge clk); #1;
        pipe_hold = 0;
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        chk("hold_release_truncout", mem_truncout, 64'd0);

        // Reset in the middle of REQ abandons the access.
        @(posedge clk); #1;
        drive(F3_LD, 1, 64'h2000, 64'h55, 64'h700);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rstreq_req_before", 64'(bus.req), 64'd1);
        rst = 1; idle_inputs();
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        chk("rstreq_req", 64'(bus.req), 64'd0);
        chk("rstreq_stall", 64'(mem_stall), 64'd0);
        chk("rstreq_truncout", mem_truncout, 64'd0);
        chk("rstreq_wmask", 64'(bus.wmask), 64'd0);
        chk("rstreq_except", except_out, 64'd0);
        @(negedge clk);
        chk("rstreq_req_after", 64'(bus.req), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The block SHALL expose: clk  in  1  sole clock; all state updates on its rising edge.
REQ-002 The block SHALL expose: rst  in  1  reset, synchronous, active-high.
REQ-003 The block SHALL expose pipeline inputs: mem_valid 1, mem_re 1, mem_we 1, mem_funct3 3 (access width/sign), mem_addr_in 64 (ALU result), mem_wdata_in 64 (rs2), mem_flush 1, pipe_hold 1 (downstream MEM/WB stall).
REQ-004 The block SHALL expose bus outputs: dmem_req 1, dmem_we 1, dmem_addr 64 (doubleword-aligned), dmem_wdata 64, dmem_wmask 8; bus inputs: dmem_ack 1, dmem_rdata 64.
REQ-005 The block SHALL expose outputs: mem_truncout 64 (load result feeding the MEM/WB register), mem_stall 1 (holds EX/MEM and upstream), except_out (ExceptPack: except, epc, ecause, etval).

Function
REQ-006 The block SHALL use FSM states IDLE, REQ, DONE, DRAIN, encoded in the shared package.
REQ-007 In IDLE, a memory op (mem_valid & (mem_re|mem_we)) without exception and without mem_flush SHALL move to REQ and assert mem_stall combinationally that cycle.
REQ-008 Non-memory or invalid instructions SHALL pass with zero added latency: mem_stall=0, mem_truncout=0.
REQ-009 In REQ, dmem_req SHALL be 1 and dmem_we/addr/wdata/wmask SHALL stay stable until dmem_ack; mem_stall SHALL stay 1.
REQ-010 On dmem_ack in REQ, the block SHALL register the truncated load data and go to DONE; minimum latency: instruction arrives cycle N, req cycle N+1, data valid cycle N+2.
REQ-011 In DONE, mem_stall SHALL be 0 and mem_truncout SHALL present the registered data; DONE->IDLE when pipe_hold=0, else remain DONE.
REQ-012 dmem_addr SHALL be {addr[63:3],3'b000}; stores SHALL shift wdata left by addr[2:0]*8 and set mask 0x01/0x03/0x0F/0xFF (SB/SH/SW/SD) shifted by addr[2:0].
REQ-013 Loads SHALL extract from dmem_rdata at byte offset addr[2:0]; funct3 000/001/010 sign-extend B/H/W, 100/101/110 zero-extend, 011 full 64 bits; funct3 111 SHALL raise illegal-instruction (cause 2).
REQ-014 mem_flush in IDLE or DONE SHALL return to IDLE next cycle with no bus request issued.
REQ-015 mem_flush in REQ without ack SHALL go to DRAIN; DRAIN holds dmem_req until dmem_ack, discards data, then IDLE; mem_stall=0 in DRAIN.
REQ-016 mem_flush and dmem_ack in the same REQ cycle SHALL go directly to IDLE, data discarded.
REQ-017 A new memory op in IDLE while a DRAIN is pending SHALL be impossible by construction; DRAIN asserts mem_stall=1 if mem_valid & (mem_re|mem_we).
REQ-018 except_out SHALL pass the incoming exception pack when no new exception arises; an exception-carrying instruction SHALL issue no bus access.

Reset
REQ-019 With rst=1 at a clock edge, state SHALL become IDLE, dmem_req=0, registered load data=0, except_out all-zero, irrespective of in-flight transactions.
REQ-020 Reset during REQ SHALL abandon the transaction; the bus agent SHALL tolerate req deassertion on reset.

Configuration
REQ-021 With MISALIGN_EXCEPT_EN defined, an access whose addr is not width-aligned SHALL issue no bus request and SHALL raise except=1, ecause=4 (load) or 6 (store), etval=mem_addr_in, epc=instruction pc.
REQ-022 Without MISALIGN_EXCEPT_EN, no alignment check SHALL exist; accesses crossing a doubleword SHALL use only bytes within the addressed doubleword (mask truncated at byte 7).

Structure
REQ-023 FSM state enum, funct3 width codes and exception cause constants SHALL live in the shared package alongside ExceptPack (ExceptStruct).
REQ-024 Load extraction/sign-extension SHALL be a combinational sub-module load_align; store shift/mask stays inline.

Verification
REQ-025 LD addr 0x1000, ack after 3 cycles, rdata 0x8877665544332211 -> mem_stall high 4 cycles, mem_truncout=0x8877665544332211.
REQ-026 LB addr 0x1007, rdata 0x80xxxxxxxxxxxxxx -> mem_truncout=0xFFFFFFFFFFFFFF80; LBU same -> 0x80.
REQ-027 SH addr 0x2002, wdata 0xBEEF -> dmem_addr=0x2000, dmem_wmask=0x0C, dmem_wdata=0x00000000BEEF0000.
REQ-028 mem_flush in REQ, ack 2 cycles later -> DRAIN holds req until ack, mem_stall=0, mem_truncout=0.
REQ-029 MISALIGN_EXCEPT_EN: LW addr 0x3002 -> dmem_req never 1, except=1, ecause=4, etval=0x3002; undefined: access issued, mask 0x3C.
REQ-030 rst asserted mid-REQ -> next cycle dmem_req=0, state IDLE, all outputs zero.
